// File: rtl/game_pkg.sv
// Shared geometry constants and helpers for the lane-crossing game.
package game_pkg;

    localparam int unsigned SCREEN_W    = 32'd640;
    localparam int unsigned LANE_Y0     = 32'd64;
    localparam int unsigned LANE_H_LOG2 = 32'd5;
    localparam int unsigned BAR_W       = 32'd64;
    localparam int unsigned SPACING     = 32'd80;
    localparam int unsigned LEVEL_CAP   = 32'd11;

    // Starting x of lane i: lanes are staggered by a fixed spacing and wrapped.
    function automatic int unsigned lane_init(
        input int unsigned i,
        input int unsigned spacing  = SPACING,
        input int unsigned screen_w = SCREEN_W
    );
        return (i * spacing) % screen_w;
    endfunction

endpackage

// File: rtl/lane_scroller_if.sv
// Bundle between the player/level logic, the lane engine and its consumers.
interface lane_scroller_if #(
    parameter int unsigned NUM_LANES = 32'd8,
    parameter int unsigned POS_W     = 32'd10,
    parameter int unsigned LEVEL_W   = 32'd10
);
    localparam int unsigned IDX_W = (NUM_LANES > 32'd1) ? $clog2(NUM_LANES) : 32'd1;

    logic                         tick;
    logic                         pause;
    logic [LEVEL_W-1:0]           level;
    logic [POS_W-1:0]             player_h;
    logic [POS_W-1:0]             player_v;
    logic [NUM_LANES*POS_W-1:0]   lane_pos;
    logic [NUM_LANES-1:0]         lane_dir;
    logic                         hit;
    logic [IDX_W-1:0]             hit_lane;
    logic                         level_ack;

    // Game logic side: drives movement/level/player, observes obstacles.
    modport master (
        output tick, pause, level, player_h, player_v,
        input  lane_pos, lane_dir, hit, hit_lane, level_ack
    );

    // Lane engine side.
    modport slave (
        input  tick, pause, level, player_h, player_v,
        output lane_pos, lane_dir, hit, hit_lane, level_ack
    );

endinterface

// File: rtl/lane_scroller_lane_unit.sv
// One obstacle lane: fractional-speed position, wrap, reload and overlap test.
module lane_unit #(
    parameter int unsigned IDX       = 32'd0,
    parameter int unsigned POS_W     = 32'd10,
    parameter int unsigned LEVEL_W   = 32'd10,
    parameter int unsigned FRAC_W    = 32'd4,
    parameter int unsigned SCREEN_W  = game_pkg::SCREEN_W,
    parameter int unsigned BAR_W     = game_pkg::BAR_W,
    parameter int unsigned LEVEL_CAP = game_pkg::LEVEL_CAP,
    parameter int unsigned SPACING   = game_pkg::SPACING,
    parameter bit          DIR_LEFT  = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_move,
    input  logic               i_reload,
    input  logic [LEVEL_W-1:0] i_level,
    input  logic [POS_W-1:0]   i_player_h,
    output logic [POS_W-1:0]   o_pos,
    output logic               o_overlap
);
    import game_pkg::*;

    localparam logic [POS_W-1:0]   INIT_POS   = POS_W'(lane_init(IDX, SPACING, SCREEN_W));
    localparam logic [POS_W-1:0]   MAX_POS    = POS_W'(SCREEN_W - 32'd1);
    localparam logic [POS_W-1:0]   ONE_POS    = POS_W'(32'd1);
    localparam logic [FRAC_W:0]    LANE_OFS   = (FRAC_W+1)'((IDX % 32'd4) + 32'd1);
    localparam logic [LEVEL_W-1:0] CAP_LVL    = LEVEL_W'(LEVEL_CAP);
    localparam logic [POS_W:0]     SCREEN_EXT = (POS_W+1)'(SCREEN_W);
    localparam logic [POS_W:0]     BAR_EXT    = (POS_W+1)'(BAR_W);

    logic [POS_W-1:0]   r_pos;
    logic [FRAC_W-1:0]  r_acc;
    logic [LEVEL_W-1:0] w_lvl_clamp;
    logic [FRAC_W:0]    w_rate;
    logic [FRAC_W:0]    w_sum;
    logic [POS_W-1:0]   w_pos_step;
    logic [POS_W:0]     w_h_ext;
    logic [POS_W:0]     w_pos_ext;
    logic [POS_W:0]     w_dist;

    // Speed: clamped level plus a per-lane offset, accumulated as a fraction.
    always_comb begin
        w_lvl_clamp = (i_level > CAP_LVL) ? CAP_LVL : i_level;
        w_rate      = (FRAC_W+1)'(w_lvl_clamp) + LANE_OFS;
        w_sum       = {1'b0, r_acc} + w_rate;
    end

    // One-pixel step in this lane's direction, wrapping at the screen edges.
    always_comb begin
        w_pos_step = r_pos;
        if (DIR_LEFT) begin
            if (r_pos == '0) begin
                w_pos_step = MAX_POS;
            end else begin
                w_pos_step = r_pos - ONE_POS;
            end
        end else begin
            if (r_pos >= MAX_POS) begin
                w_pos_step = '0;
            end else begin
                w_pos_step = r_pos + ONE_POS;
            end
        end
    end

    // Lane state: reload wins over motion; a carry out of the accumulator moves 1 px.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pos <= INIT_POS;
            r_acc <= '0;
        end else if (i_reload) begin
            r_pos <= INIT_POS;
            r_acc <= '0;
        end else if (i_move) begin
            r_acc <= w_sum[FRAC_W-1:0];
            if (w_sum[FRAC_W]) begin
                r_pos <= w_pos_step;
            end
        end
    end

    // Horizontal overlap with wrap-around distance, from the current position.
    always_comb begin
        w_h_ext   = {1'b0, i_player_h};
        w_pos_ext = {1'b0, r_pos};
        if (i_player_h >= r_pos) begin
            w_dist = w_h_ext - w_pos_ext;
        end else begin
            w_dist = w_h_ext + SCREEN_EXT - w_pos_ext;
        end
        o_overlap = (w_h_ext < SCREEN_EXT) && (w_dist < BAR_EXT);
    end

    assign o_pos = r_pos;

endmodule

// File: rtl/lane_scroller.sv
// Obstacle-lane engine: NUM_LANES scrolling lanes, level reload, registered hit.
module lane_scroller #(
    parameter int unsigned NUM_LANES   = 32'd8,
    parameter int unsigned POS_W       = 32'd10,
    parameter int unsigned LEVEL_W     = 32'd10,
    parameter int unsigned SCREEN_W    = game_pkg::SCREEN_W,
    parameter int unsigned BAR_W       = game_pkg::BAR_W,
    parameter int unsigned FRAC_W      = 32'd4,
    parameter int unsigned LEVEL_CAP   = game_pkg::LEVEL_CAP,
    parameter int unsigned SPACING     = game_pkg::SPACING,
    parameter int unsigned LANE_Y0     = game_pkg::LANE_Y0,
    parameter int unsigned LANE_H_LOG2 = game_pkg::LANE_H_LOG2,
    parameter int unsigned ALT_DIR     = 32'd1
) (
    input  logic           clk,
    input  logic           reset,
    lane_scroller_if.slave bus
);
    import game_pkg::*;

    localparam int unsigned    IDX_W  = (NUM_LANES > 32'd1) ? $clog2(NUM_LANES) : 32'd1;
    localparam logic [POS_W-1:0] ROW_Y0 = POS_W'(LANE_Y0);
    localparam logic [POS_W-1:0] ROW_NL = POS_W'(NUM_LANES);

    // Odd lanes scroll left when alternation is enabled.
    function automatic logic [NUM_LANES-1:0] dir_mask();
        logic [NUM_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            m[i] = (ALT_DIR != 32'd0) && ((i % 2) == 1);
        end
        return m;
    endfunction

    localparam logic [NUM_LANES-1:0] DIR_MASK = dir_mask();

    logic [LEVEL_W-1:0]         r_level_q;
    logic                       r_level_ack;
    logic                       r_hit;
    logic [IDX_W-1:0]           r_hit_lane;
    logic                       w_reload;
    logic                       w_move;
    logic [NUM_LANES-1:0]       w_overlap;
    logic [NUM_LANES*POS_W-1:0] w_lane_pos;
    logic [POS_W-1:0]           w_row_off;
    logic [POS_W-1:0]           w_row;
    logic                       w_row_ok;
    logic                       w_hit;

    // A level change reloads all lanes and swallows any coincident tick.
    always_comb begin
        w_reload = (bus.level != r_level_q);
        w_move   = bus.tick & ~bus.pause & ~w_reload;
    end

    // Map player y onto a lane row and pick that lane's overlap flag.
    always_comb begin
        w_row_off = bus.player_v - ROW_Y0;
        w_row     = w_row_off >> LANE_H_LOG2;
        w_row_ok  = (bus.player_v >= ROW_Y0) && (w_row < ROW_NL);
        if (w_row_ok) begin
            w_hit = w_overlap[w_row[IDX_W-1:0]];
        end else begin
            w_hit = 1'b0;
        end
    end

    for (genvar gi = 0; gi < int'(NUM_LANES); gi++) begin : g_lane
        lane_unit #(
            .IDX       (gi),
            .POS_W     (POS_W),
            .LEVEL_W   (LEVEL_W),
            .FRAC_W    (FRAC_W),
            .SCREEN_W  (SCREEN_W),
            .BAR_W     (BAR_W),
            .LEVEL_CAP (LEVEL_CAP),
            .SPACING   (SPACING),
            .DIR_LEFT  (DIR_MASK[gi])
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .i_move     (w_move),
            .i_reload   (w_reload),
            .i_level    (bus.level),
            .i_player_h (bus.player_h),
            .o_pos      (w_lane_pos[gi*POS_W +: POS_W]),
            .o_overlap  (w_overlap[gi])
        );
    end

    // Level tracking, reload acknowledge and registered collision result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level_q   <= '0;
            r_level_ack <= 1'b0;
            r_hit       <= 1'b0;
            r_hit_lane  <= '0;
        end else begin
            r_level_ack <= w_reload;
            if (w_reload) begin
                r_level_q <= bus.level;
            end
            r_hit <= w_hit;
            if (w_hit) begin
                r_hit_lane <= w_row[IDX_W-1:0];
            end
        end
    end

    assign bus.lane_pos  = w_lane_pos;
    assign bus.lane_dir  = DIR_MASK;
    assign bus.hit       = r_hit;
    assign bus.hit_lane  = r_hit_lane;
    assign bus.level_ack = r_level_ack;

endmodule

// File: tb/tb_lane_scroller.sv
// Directed self-checking bench for lane_scroller with default parameters.
module tb_lane_scroller;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   n;

    localparam logic [79:0] INIT_V =
        {10'd560, 10'd480, 10'd400, 10'd320, 10'd240, 10'd160, 10'd80, 10'd0};

    lane_scroller_if #(.NUM_LANES(8), .POS_W(10), .LEVEL_W(10)) bus ();

    lane_scroller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] lane(input int i);
        return bus.lane_pos[i*10 +: 10];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b1;
        bus.tick     = 1'b0;
        bus.pause    = 1'b0;
        bus.level    = 10'd0;
        bus.player_h = 10'd0;
        bus.player_v = 10'd0;
        #12;
        reset = 1'b0;
        step();

        // Reset state
        chk("rst_pos", bus.lane_pos, INIT_V);
        chk("rst_dir", bus.lane_dir, 80'haa);
        chk("rst_hit", bus.hit, 80'd0);
        chk("rst_hit_lane", bus.hit_lane, 80'd0);
        chk("rst_ack", bus.level_ack, 80'd0);

        // Collisions against the reset layout
        bus.player_v = 10'd133; bus.player_h = 10'd200;
        step();
        chk("hit_l2", bus.hit, 80'd1);
        chk("hit_lane_l2", bus.hit_lane, 80'd2);
        bus.player_h = 10'd224;
        #1;
        chk("hit_lag", bus.hit, 80'd1);
        step();
        chk("miss_edge64", bus.hit, 80'd0);
        chk("hit_lane_hold", bus.hit_lane, 80'd2);
        bus.player_h = 10'd160;
        step();
        chk("hit_edge0", bus.hit, 80'd1);
        bus.player_h = 10'd159;
        step();
        chk("miss_left", bus.hit, 80'd0);
        bus.player_v = 10'd319; bus.player_h = 10'd600;
        step();
        chk("hit_l7", bus.hit, 80'd1);
        chk("hit_lane_l7", bus.hit_lane, 80'd7);
        bus.player_v = 10'd320; bus.player_h = 10'd10;
        step();
        chk("miss_row8", bus.hit, 80'd0);
        bus.player_v = 10'd0;

        // Level 0, 16 ticks
        for (int i = 0; i < 16; i++) tick_once();
        chk("l0_lane0", lane(0), 80'd1);
        chk("l0_lane1", lane(1), 80'd78);
        chk("l0_lane3", lane(3), 80'd236);
        chk("l0_lane4", lane(4), 80'd321);
        chk("l0_all", bus.lane_pos,
            {10'd556, 10'd483, 10'd398, 10'd321, 10'd236, 10'd163, 10'd78, 10'd1});

        // Level change with a coincident tick
        bus.level = 10'd3; bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        chk("reload_ack", bus.level_ack, 80'd1);
        chk("reload_pos", bus.lane_pos, INIT_V);
        step();
        chk("reload_ack_once", bus.level_ack, 80'd0);
        for (int i = 0; i < 3; i++) tick_once();
        chk("l3_lane0_3t", lane(0), 80'd0);
        tick_once();
        chk("l3_lane0_4t", lane(0), 80'd1);
        tick_once();
        tick_once();

        // Pause holds position and accumulator
        bus.pause = 1'b1;
        for (int i = 0; i < 100; i++) tick_once();
        chk("pause_hold", bus.lane_pos,
            {10'd558, 10'd482, 10'd399, 10'd321, 10'd238, 10'd162, 10'd79, 10'd1});
        bus.pause = 1'b0;
        tick_once();
        chk("resume_lane0", lane(0), 80'd1);
        chk("resume_lane1", lane(1), 80'd78);
        tick_once();
        chk("resume_lane0_2", lane(0), 80'd2);

        // Reload while paused
        bus.pause = 1'b1; bus.level = 10'd11;
        step();
        chk("pause_reload_ack", bus.level_ack, 80'd1);
        chk("pause_reload_pos", bus.lane_pos, INIT_V);
        bus.pause = 1'b0;
        step();
        chk("pause_reload_ack_off", bus.level_ack, 80'd0);

        // Left-moving wrap 0 -> 639
        n = 0;
        while (lane(1) != 10'd0 && n < 500) begin tick_once(); n++; end
        chk("lane1_reach0", lane(1), 80'd0);
        n = 0;
        while (lane(1) == 10'd0 && n < 10) begin tick_once(); n++; end
        chk("lane1_wrap", lane(1), 80'd639);
        chk("lane1_dir", bus.lane_dir[1], 80'd1);

        // Wrap-straddling collision with lane6 at 600
        n = 0;
        while (lane(6) != 10'd600 && n < 500) begin tick_once(); n++; end
        chk("lane6_reach600", lane(6), 80'd600);
        bus.player_v = 10'd261; bus.player_h = 10'd10;
        step();
        chk("wrap_hit", bus.hit, 80'd1);
        chk("wrap_hit_lane", bus.hit_lane, 80'd6);
        bus.player_h = 10'd24;
        step();
        chk("wrap_miss", bus.hit, 80'd0);
        bus.player_v = 10'd0;

        // Right-moving wrap 639 -> 0
        n = 0;
        while (lane(0) != 10'd639 && n < 2000) begin tick_once(); n++; end
        chk("lane0_reach639", lane(0), 80'd639);
        n = 0;
        while (lane(0) == 10'd639 && n < 10) begin tick_once(); n++; end
        chk("lane0_wrap", lane(0), 80'd0);

        // Asynchronous reset mid-operation
        bus.player_v = 10'd64; bus.player_h = 10'd5;
        step();
        chk("pre_rst_hit", bus.hit, 80'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_pos", bus.lane_pos, INIT_V);
        chk("mid_rst_hit", bus.hit, 80'd0);
        chk("mid_rst_ack", bus.level_ack, 80'd0);
        #3;
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
